// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM encoding,
// board button channel indices and the counter width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_e;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_CENTER = 4;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the board pins, the debouncer and the game controller.
interface btn_debouncer_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_debouncer_channel.sv
// Single-bit debouncer: 2-FF synchronizer, qualification counter and a
// four-state FSM producing a registered level plus press/release pulses.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The counter only advances while below CNT_LAST, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Level is the high half of the state encoding, so it is a flop output.
  assign level_o   = (state_q == HIGH) || (state_q == WAIT_LOW);
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel push-button conditioner: N_BTN independent debounce channels
// feeding the controller with clean levels and one-cycle press/release pulses.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 2500000
) (
  input  logic         clk,
  input  logic         rst,
  btn_debouncer_if.slave bus
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (bus.btn_in[i]),
      .level_o  (bus.btn_level[i]),
      .press_o  (bus.btn_press[i]),
      .release_o(bus.btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: expectations per clock are queued as
// stimulus is applied and compared on the falling edge of that clock.
module tb_btn_debouncer;
  import btn_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned DC = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  btn_debouncer_if #(.N_BTN(N)) bus ();

  btn_debouncer #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input int c, input logic [4:0] l, input logic [4:0] p, input logic [4:0] r);
    exp_t e;
    e.cyc = c;
    e.lvl = l;
    e.prs = p;
    e.rel = r;
    sb.push_back(e);
  endtask

  // Steady level with no pulses over an inclusive range of cycles.
  task automatic hold(input int c0, input int c1, input logic [4:0] l);
    for (int c = c0; c <= c1; c++) push(c, l, 5'b0, 5'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_assert++;
      assert (bus.btn_level === e.lvl) else begin
        n_fail++;
        $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, bus.btn_level, e.lvl);
      end
      n_assert++;
      assert (bus.btn_press === e.prs) else begin
        n_fail++;
        $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, bus.btn_press, e.prs);
      end
      n_assert++;
      assert (bus.btn_release === e.rel) else begin
        n_fail++;
        $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, bus.btn_release, e.rel);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    // Reset held with all buttons down; they count as fresh presses after release.
    rst        = 1'b1;
    bus.btn_in = 5'b11111;
    hold(1, 3, 5'h00);
    wait_cyc(3);
    rst = 1'b0;
    hold(4, 12, 5'h00);
    push(13, 5'h1f, 5'h1f, 5'h00);
    hold(14, 20, 5'h1f);

    wait_cyc(20);
    bus.btn_in = 5'b00000;
    hold(21, 29, 5'h1f);
    push(30, 5'h00, 5'h00, 5'h1f);
    hold(31, 40, 5'h00);

    // Clean press on ch0.
    wait_cyc(40);
    bus.btn_in = 5'b00001;
    hold(41, 49, 5'h00);
    push(50, 5'h01, 5'h01, 5'h00);
    hold(51, 56, 5'h01);

    // Bounce on ch1: 1,0,1,0 every 3 cycles, then held high from cycle 68.
    wait_cyc(56);
    bus.btn_in = 5'b00011;
    hold(57, 77, 5'h01);
    push(78, 5'h03, 5'h02, 5'h00);
    hold(79, 86, 5'h03);
    wait_cyc(59); bus.btn_in = 5'b00001;
    wait_cyc(62); bus.btn_in = 5'b00011;
    wait_cyc(65); bus.btn_in = 5'b00001;
    wait_cyc(68); bus.btn_in = 5'b00011;

    // Glitch on ch2: high for DC-1 cycles only.
    wait_cyc(86);
    bus.btn_in = 5'b00111;
    hold(87, 111, 5'h03);
    wait_cyc(93);
    bus.btn_in = 5'b00011;

    // Release of ch0.
    wait_cyc(111);
    bus.btn_in = 5'b00010;
    hold(112, 120, 5'h03);
    push(121, 5'h02, 5'h00, 5'h01);
    hold(122, 126, 5'h02);

    // ch3 and ch4 pressed four cycles apart, then both released.
    wait_cyc(126);
    bus.btn_in = 5'b01010;
    hold(127, 135, 5'h02);
    push(136, 5'h0a, 5'h08, 5'h00);
    hold(137, 139, 5'h0a);
    push(140, 5'h1a, 5'h10, 5'h00);
    hold(141, 146, 5'h1a);
    wait_cyc(130);
    bus.btn_in = 5'b11010;

    wait_cyc(146);
    bus.btn_in = 5'b00010;
    hold(147, 155, 5'h1a);
    push(156, 5'h02, 5'h00, 5'h18);
    hold(157, 161, 5'h02);

    // Same presses again, cut by a short reset pulse between clock edges.
    wait_cyc(161);
    bus.btn_in = 5'b01010;
    hold(162, 168, 5'h02);
    hold(169, 177, 5'h00);
    push(178, 5'h1a, 5'h1a, 5'h00);
    hold(179, 183, 5'h1a);
    wait_cyc(165);
    bus.btn_in = 5'b11010;
    wait_cyc(168);
    #1 rst = 1'b1;
    #1;
    n_assert++;
    assert (bus.btn_level === 5'b0 && bus.btn_press === 5'b0 && bus.btn_release === 5'b0) else begin
      n_fail++;
      $error("FAIL async_clear observed=%b/%b/%b expected=00000/00000/00000",
             bus.btn_level, bus.btn_press, bus.btn_release);
    end
    #1 rst = 1'b0;

    wait_cyc(183);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
- Multi-channel push-button conditioner that sits directly upstream of the game/block controller.
- Each channel takes a raw, bouncing, asynchronous board button (left, right, up, down, center).
- It produces a clean debounced level, which drives the controller's left/right hold-to-move inputs.
- It also produces one-cycle press and release pulses for menu/serve/reset-style actions.
- Runs on the fast board clock, not the slow game clock.

Parameters:
- N_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 2500000, consecutive stable synchronized cycles required to accept a level change (25 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- clk  input  1  fast system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  N_BTN  raw button pins, asynchronous to clk.
- btn_level  output  N_BTN  debounced level, registered.
- btn_press  output  N_BTN  one-cycle pulse when btn_level goes 0→1, registered.
- btn_release  output  N_BTN  one-cycle pulse when btn_level goes 1→0, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Channels are fully independent. Identical logic is instanced N_BTN times; no cross-channel interaction.
- Synchronizer: 2-FF chain per channel, s1 <= btn_in, s2 <= s1. Only s2 is used downstream.
- Per-channel FSM states:
  - LOW: level 0, count 0.
  - WAIT_HIGH: s2=1 seen while level 0, counting.
  - HIGH: level 1, count 0.
  - WAIT_LOW: s2=0 seen while level 1, counting.
- Transitions:
  - LOW: s2=1 → WAIT_HIGH, count<=1. Otherwise stay.
  - WAIT_HIGH: s2=0 → LOW, count<=0 (glitch rejected, no output change).
  - WAIT_HIGH: s2=1 and count==DEBOUNCE_CYCLES-1 → HIGH. Assert btn_level<=1 and btn_press<=1 on that edge.
  - WAIT_HIGH: otherwise count<=count+1.
  - HIGH and WAIT_LOW: mirror image. Acceptance asserts btn_level<=0 and btn_release<=1.
- Latency: btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new btn_in value. This holds only if btn_in stays stable the whole time.
- Pulses: btn_press and btn_release are high exactly one cycle. They are never both high on the same channel in the same cycle.
- Counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset values: s1, s2, btn_level, btn_press and btn_release are all 0; FSM state is LOW; count is 0.
- Reset mid-operation: all state clears immediately, with no pulse emitted.
  - A button held through reset release is treated as a new press.
  - It yields btn_press after the full latency.
- Bounce: any opposite sample during WAIT_* restarts qualification from zero. Continuous bounce faster than DEBOUNCE_CYCLES never changes btn_level.
- Simultaneous presses on multiple channels each follow their own timing exactly.

Decomposition:
- Shared package btn_pkg:
  - FSM state encoding (LOW=2'b00, WAIT_HIGH=2'b01, HIGH=2'b10, WAIT_LOW=2'b11).
  - Channel index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_CENTER=4, used by the top level when wiring to the controller.
- One sub-module debounce_channel: synchronizer, counter and FSM for a single bit, parameterized by DEBOUNCE_CYCLES.
- btn_debouncer is a generate loop over N_BTN instances.

Test Plan (bench uses DEBOUNCE_CYCLES=8, N_BTN=5):
- Reset: hold rst 3 cycles with btn_in=5'b11111 → all outputs 0 during reset. After release, btn_level=5'b11111 and btn_press=5'b11111 for one cycle at edge 10.
- Clean press: ch0 rises and is held → btn_level[0]=1 and btn_press[0]=1 at edge 10 after the first sampling edge. Press pulse lasts exactly one cycle; level stays 1.
- Bounce: ch1 toggles 1,0,1,0 every 3 cycles, then holds 1 → no output change during bouncing. btn_level[1] rises 10 edges after the final rising sample.
- Glitch reject: ch2 high for 7 cycles, then low → btn_level[2] stays 0; no btn_press.
- Release: ch0 held high (level 1), then dropped → btn_level[0]=0 and btn_release[0]=1 at edge 10; btn_press stays 0.
- Independence plus async reset mid-count: press ch3 and ch4 offset by 4 cycles → pulses at edges 10 and 14. Repeat with rst asserted at count 5 → immediate clear, no pulses, restart after reset.
